// File: rtl/dmem_responder.sv
// Data-memory responder: programmable-latency load/store port over a byte-laned word array.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses with mem_err instead of aligning them down.
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] write_data,
    input  logic        load_en,
    input  logic        store_en,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    output logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            store_q;
    logic            err_q;
    logic [31:0]     mem [DEPTH];

    logic [AW+1:0]   acc_addr_c;
    logic            acc_err_c;
    logic            req_c;
    logic            resp_next_c;
    logic [AW+1:0]   rd_addr_c;
    logic [1:0]      rd_size_c;
    logic            rd_uns_c;
    logic            rd_store_c;
    logic            rd_err_c;
    logic [31:0]     rd_word_c;
    logic [3:0]      be_c;
    logic [31:0]     wlane_c;
    logic            unused_addr_hi;

    function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] size);
        misaligned = (size == 2'b01 && lo[0]) || (size[1] && lo != 2'b00);
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] lo, input logic [1:0] size);
        case (size)
            2'b00:   align_lo = lo;
            2'b01:   align_lo = {lo[1], 1'b0};
            default: align_lo = 2'b00;
        endcase
    endfunction

    // Shift the addressed lane(s) down to bit 0 and extend; word loads pass through.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] size, input logic uns);
        logic [31:0] s;
        s = word >> {lane, 3'b000};
        case (size)
            2'b00:   extract = uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'b01:   extract = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: extract = word;
        endcase
    endfunction

    assign unused_addr_hi = ^mem_addr[31:AW+2];
    assign req_c          = load_en | store_en;
    assign acc_addr_c     = {mem_addr[AW+1:2],
                             TRAP ? mem_addr[1:0] : align_lo(mem_addr[1:0], mem_size)};
    assign acc_err_c      = TRAP & misaligned(mem_addr[1:0], mem_size);
    assign resp_next_c    = (state == IDLE && req_c && LATENCY == 0) ||
                            (state == WAIT && cnt == CW'(1));

    // With zero latency the array is read straight from the request inputs.
    always_comb begin
        rd_addr_c  = addr_q;
        rd_size_c  = size_q;
        rd_uns_c   = uns_q;
        rd_store_c = store_q;
        rd_err_c   = err_q;
        if (state == IDLE) begin
            rd_addr_c  = acc_addr_c;
            rd_size_c  = mem_size;
            rd_uns_c   = load_unsigned;
            rd_store_c = store_en;
            rd_err_c   = acc_err_c;
        end
        rd_word_c = mem[rd_addr_c[AW+1:2]];
    end

    always_comb begin
        be_c    = 4'b1111;
        wlane_c = wdata_q;
        case (size_q)
            2'b00: begin
                be_c    = 4'b0001 << addr_q[1:0];
                wlane_c = wdata_q << {addr_q[1:0], 3'b000};
            end
            2'b01: begin
                be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane_c = wdata_q << {addr_q[1], 4'b0000};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            store_q   <= 1'b0;
            err_q     <= 1'b0;
            mem_data  <= '0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_c) begin
                        addr_q   <= acc_addr_c;
                        wdata_q  <= write_data;
                        size_q   <= mem_size;
                        uns_q    <= load_unsigned;
                        store_q  <= store_en;
                        err_q    <= acc_err_c;
                        mem_busy <= 1'b1;
                        cnt      <= CW'(LATENCY);
                        state    <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CW'(1)) state <= RESP;
                    else               cnt   <= cnt - CW'(1);
                end
                RESP: begin
                    state    <= IDLE;
                    mem_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (resp_next_c) begin
                mem_ready <= 1'b1;
                mem_err   <= rd_err_c;
                if (!rd_store_c && !rd_err_c)
                    mem_data <= extract(rd_word_c, rd_addr_c[1:0], rd_size_c, rd_uns_c);
            end
        end
    end

    // Store lanes commit on the edge that ends RESP; reset drops state so nothing commits.
    always_ff @(posedge clk) begin
        if (state == RESP && store_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wlane_c[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores, latency, reset abort and aliasing.
module tb_dmem_responder;
    localparam int unsigned LATENCY = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] write_data = '0;
    logic        load_en = 1'b0;
    logic        store_en = 1'b0;
    logic [1:0]  mem_size = '0;
    logic        load_unsigned = 1'b0;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        mem_busy;
    logic        mem_err;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] last = '0;

    dmem_responder #(.DEPTH(256), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .write_data(write_data),
        .load_en(load_en), .store_en(store_en), .mem_size(mem_size),
        .load_unsigned(load_unsigned), .mem_data(mem_data), .mem_ready(mem_ready),
        .mem_busy(mem_busy), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ready", 32'(mem_ready), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", mem_data, e.data);
                    check("resp_err", 32'(mem_err), 32'(e.err));
                end
            end
        end
    end

    task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic ld, input logic st,
                        input logic [1:0] sz, input logic un, input logic [31:0] exp_d,
                        input logic exp_e);
        int k;
        @(negedge clk);
        mem_addr = a; write_data = wd; mem_size = sz; load_unsigned = un;
        load_en = ld; store_en = st;
        exp_q.push_back('{data: exp_d, err: exp_e});
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mem_ready && k < 20);
        check("latency", 32'(k), 32'(LATENCY + 1));
        check("busy_resp", 32'(mem_busy), 32'd1);
        load_en = 1'b0; store_en = 1'b0;
        @(negedge clk);
        check("busy_idle", 32'(mem_busy), 32'd0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        xact(a, wd, 1'b0, 1'b1, sz, 1'b0, last, 1'b0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic un,
                      input logic [31:0] d);
        xact(a, 32'h0, 1'b1, 1'b0, sz, un, d, 1'b0);
        last = d;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_data", mem_data, 32'h0);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_busy", 32'(mem_busy), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        rst = 1'b1;

        st(32'h10, 32'hDEADBEEF, 2'b10);
        ld(32'h10, 2'b10, 1'b0, 32'hDEADBEEF);

        st(32'h10, 32'h0, 2'b10);
        st(32'h13, 32'h123456A5, 2'b00);
        ld(32'h13, 2'b00, 1'b0, 32'hFFFFFFA5);
        ld(32'h13, 2'b00, 1'b1, 32'h000000A5);
        ld(32'h10, 2'b10, 1'b0, 32'hA5000000);

        st(32'h10, 32'h11223344, 2'b10);
        st(32'h12, 32'hABCD8001, 2'b01);
        ld(32'h12, 2'b01, 1'b0, 32'hFFFF8001);
        ld(32'h12, 2'b01, 1'b1, 32'h00008001);
        ld(32'h10, 2'b00, 1'b1, 32'h00000044);
        ld(32'h11, 2'b00, 1'b0, 32'h00000033);

        // Misaligned half store and word load at word 0x10 (0x80013344).
        if (TRAP) begin
            xact(32'h11, 32'h0000BEEF, 1'b0, 1'b1, 2'b01, 1'b0, last, 1'b1);
            ld(32'h10, 2'b10, 1'b0, 32'h80013344);
            xact(32'h12, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, last, 1'b1);
        end else begin
            st(32'h11, 32'h0000BEEF, 2'b01);
            ld(32'h10, 2'b10, 1'b0, 32'h8001BEEF);
            ld(32'h12, 2'b10, 1'b0, 32'h8001BEEF);
        end

        // Reset in the middle of a store's wait phase.
        st(32'h20, 32'hCAFEF00D, 2'b10);
        @(negedge clk);
        mem_addr = 32'h20; write_data = 32'h12345678; mem_size = 2'b10; store_en = 1'b1;
        @(negedge clk);
        check("wait_busy", 32'(mem_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_data", mem_data, 32'h0);
        check("abort_ready", 32'(mem_ready), 32'd0);
        check("abort_busy", 32'(mem_busy), 32'd0);
        check("abort_err", 32'(mem_err), 32'd0);
        store_en = 1'b0;
        last = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        ld(32'h20, 2'b10, 1'b0, 32'hCAFEF00D);

        // Aliasing modulo DEPTH*4 and sub-word loads of the aliased word.
        st(32'h400, 32'h0BADF00D, 2'b10);
        ld(32'h000, 2'b10, 1'b0, 32'h0BADF00D);
        ld(32'h000, 2'b01, 1'b0, 32'hFFFFF00D);
        ld(32'h001, 2'b00, 1'b0, 32'hFFFFFFF0);
        ld(32'h002, 2'b01, 1'b1, 32'h00000BAD);

        // Both enables high: the store wins and mem_data is left alone.
        xact(32'h40, 32'h5A5A5A5A, 1'b1, 1'b1, 2'b10, 1'b0, last, 1'b0);
        ld(32'h40, 2'b11, 1'b0, 32'h5A5A5A5A);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
